// File: rtl/snu_board_if.sv
// Board pin bundle for the six-switch / six-display / six-LED training board.
// The board side (master) drives the switches and observes displays and LEDs;
// the display controller (slave) reads the switches and drives the pins.
interface snu_board_if;
  logic       SW1, SW2, SW3, SW4, SW5, SW6;
  logic [6:0] J1, J2, J3, J4, J5, J6;
  logic       D1, D2, D3, D4, D5, D6;

  modport master (
    output SW1, SW2, SW3, SW4, SW5, SW6,
    input  J1, J2, J3, J4, J5, J6,
    input  D1, D2, D3, D4, D5, D6
  );

  modport slave (
    input  SW1, SW2, SW3, SW4, SW5, SW6,
    output J1, J2, J3, J4, J5, J6,
    output D1, D2, D3, D4, D5, D6
  );
endinterface

// File: rtl/snu_board.sv
// Display controller for the training board. The switch word
// V = {SW1..SW6} (SW1 is the MSB) is decoded into decimal tens/ones, hex high/low
// nibble, popcount and first-active-switch index, each shown as an active-high
// {a,b,c,d,e,f,g} glyph. LEDs mirror the switches. All outputs are registered
// with one cycle of latency and are cleared asynchronously while rst_n is low.
module snu_board (
  input  logic         clk,
  input  logic         rst_n,
  snu_board_if.slave   bus
);

  logic [5:0] v;
  logic [5:0] tens;
  logic [5:0] ones;
  logic [3:0] pop;
  logic [3:0] first;

  assign v = {bus.SW1, bus.SW2, bus.SW3, bus.SW4, bus.SW5, bus.SW6};

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'd126;
      4'h1:    g = 7'd48;
      4'h2:    g = 7'd109;
      4'h3:    g = 7'd121;
      4'h4:    g = 7'd51;
      4'h5:    g = 7'd91;
      4'h6:    g = 7'd95;
      4'h7:    g = 7'd112;
      4'h8:    g = 7'd127;
      4'h9:    g = 7'd123;
      4'hA:    g = 7'd119;
      4'hB:    g = 7'd31;
      4'hC:    g = 7'd78;
      4'hD:    g = 7'd61;
      4'hE:    g = 7'd79;
      4'hF:    g = 7'd71;
      default: g = 7'd0;
    endcase
    return g;
  endfunction

  // Decimal split; V tops out at 63 so tens never exceeds 6.
  always_comb begin
    tens = v / 6'd10;
    ones = v % 6'd10;
  end

  // Count the active switches.
  always_comb begin
    pop = 4'd0;
    for (int i = 0; i < 6; i++) begin
      pop = pop + {3'b000, v[i]};
    end
  end

  // Lowest-numbered active switch; scanning from SW6 up lets SW1 win last.
  always_comb begin
    first = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) begin
        first = 4'(6 - i);
      end
    end
  end

  // Register every display and LED from the switch word seen at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.J1 <= 7'd0;
      bus.J2 <= 7'd0;
      bus.J3 <= 7'd0;
      bus.J4 <= 7'd0;
      bus.J5 <= 7'd0;
      bus.J6 <= 7'd0;
      bus.D1 <= 1'b0;
      bus.D2 <= 1'b0;
      bus.D3 <= 1'b0;
      bus.D4 <= 1'b0;
      bus.D5 <= 1'b0;
      bus.D6 <= 1'b0;
    end else begin
      bus.J1 <= glyph(tens[3:0]);
      bus.J2 <= glyph(ones[3:0]);
      bus.J3 <= glyph({2'b00, v[5:4]});
      bus.J4 <= glyph(v[3:0]);
      bus.J5 <= glyph(pop);
      bus.J6 <= glyph(first);
      bus.D1 <= bus.SW1;
      bus.D2 <= bus.SW2;
      bus.D3 <= bus.SW3;
      bus.D4 <= bus.SW4;
      bus.D5 <= bus.SW5;
      bus.D6 <= bus.SW6;
    end
  end

endmodule

// File: tb/tb_snu_board.sv
// Bench for snu_board: directed values, an exhaustive sweep with mid-cycle
// switch changes, and an asynchronous reset in the middle of the sweep.
module tb_snu_board;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  snu_board_if bif ();

  snu_board dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  typedef struct packed {
    logic [6:0] j1, j2, j3, j4, j5, j6;
    logic [5:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int checks = 0;
  int passes = 0;
  logic [6:0] gl [16];

  function automatic exp_t model(input logic [5:0] v);
    exp_t m;
    int t;
    int r;
    int k;
    t = 0;
    r = int'(v);
    while (r >= 10) begin
      r -= 10;
      t++;
    end
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      if (k == 0 && v[6 - i]) k = i;
    end
    m.j1 = gl[t];
    m.j2 = gl[r];
    m.j3 = gl[int'(v) >> 4];
    m.j4 = gl[int'(v) & 15];
    m.j5 = gl[$countones(v)];
    m.j6 = gl[k];
    m.d  = v;
    return m;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.j1 = bif.J1;
    o.j2 = bif.J2;
    o.j3 = bif.J3;
    o.j4 = bif.J4;
    o.j5 = bif.J5;
    o.j6 = bif.J6;
    o.d  = {bif.D1, bif.D2, bif.D3, bif.D4, bif.D5, bif.D6};
    return o;
  endfunction

  task automatic set_v(input logic [5:0] v);
    {bif.SW1, bif.SW2, bif.SW3, bif.SW4, bif.SW5, bif.SW6} = v;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cmp(input string tag, input exp_t o, input exp_t e);
    chk({tag, ".J1"}, o.j1, e.j1);
    chk({tag, ".J2"}, o.j2, e.j2);
    chk({tag, ".J3"}, o.j3, e.j3);
    chk({tag, ".J4"}, o.j4, e.j4);
    chk({tag, ".J5"}, o.j5, e.j5);
    chk({tag, ".J6"}, o.j6, e.j6);
    chk({tag, ".D"}, {1'b0, o.d}, {1'b0, e.d});
  endtask

  // Drive V away from the edge, expect it one edge later.
  task automatic step(input logic [5:0] v, input string tag);
    @(negedge clk);
    set_v(v);
    sb.push_back(model(v));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      last = sb.pop_front();
      cmp(tag, observe(), last);
    end
  endtask

  initial begin
    gl = '{7'd126, 7'd48, 7'd109, 7'd121, 7'd51, 7'd91, 7'd95, 7'd112,
           7'd127, 7'd123, 7'd119, 7'd31, 7'd78, 7'd61, 7'd79, 7'd71};

    // Reset held with all switches on.
    rst_n = 1'b0;
    set_v(6'd63);
    repeat (3) @(posedge clk);
    #1;
    cmp("reset", observe(), '0);

    @(negedge clk);
    rst_n = 1'b1;
    step(6'd63, "rel63");
    cmp("rel63_lit", observe(),
        {7'd95, 7'd121, 7'd121, 7'd71, 7'd95, 7'd48, 6'b111111});

    step(6'd0, "v0");
    cmp("v0_lit", observe(),
        {7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126, 6'b000000});

    step(6'd63, "v63");
    cmp("v63_lit", observe(),
        {7'd95, 7'd121, 7'd121, 7'd71, 7'd95, 7'd48, 6'b111111});

    step(6'd37, "v37");
    cmp("v37_lit", observe(),
        {7'd121, 7'd112, 7'd109, 7'd91, 7'd121, 7'd48, 6'b100101});

    step(6'd10, "v10");
    cmp("v10_lit", observe(),
        {7'd48, 7'd126, 7'd126, 7'd119, 7'd109, 7'd121, 6'b001010});

    // Sweep; flip the switches mid-cycle and confirm the outputs hold.
    for (int v = 0; v < 64; v++) begin
      step(6'(v), $sformatf("sweep%0d", v));
      #2;
      set_v(~6'(v));
      #3;
      cmp($sformatf("hold%0d", v), observe(), last);
      if (v == 40) begin
        rst_n = 1'b0;
        #1;
        cmp("midrst", observe(), '0);
        @(posedge clk);
        #1;
        cmp("midrst_hold", observe(), '0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snu_board.md
Name: snu_board

Overview:
Board-level display controller for the six-switch / six-display / six-LED training board. It samples the 6-bit switch word every clock and drives six 7-segment displays: decimal value, hex value, popcount and a first-active-switch index. It also drives six LEDs that mirror the switches. This is the top-level user logic between the board switches and the display/LED pins.

Parameters:
None. All widths are fixed: 6 switches, 7-bit segment buses.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
SW1  input  1  switch 1; MSB of switch word V
SW2  input  1  switch 2
SW3  input  1  switch 3
SW4  input  1  switch 4
SW5  input  1  switch 5
SW6  input  1  switch 6; LSB of V
J1  output  7  display 1: decimal tens digit of V
J2  output  7  display 2: decimal ones digit of V
J3  output  7  display 3: hex high nibble of V (0..3)
J4  output  7  display 4: hex low nibble of V
J5  output  7  display 5: popcount of V (0..6)
J6  output  7  display 6: index of lowest-numbered active switch (1..6), 0 if none
D1..D6  output  1 each  LED k mirrors SWk

Behaviour:
- V = {SW1,SW2,SW3,SW4,SW5,SW6}, unsigned 0..63.
- All outputs are registered. Each rising edge of clk loads every output from the V present at that edge. Latency is 1 cycle, and the outputs hold between edges.
- The switches are not synchronised internally. Stable switch levels are supplied by the board/bench.
- Reset: rst_n low immediately clears J1..J6 to 7'd0 (all segments off) and D1..D6 to 0, independent of clk, and holds them while low. The first rising edge after release loads normal values.
- Segment encoding is active-high, J[6:0] = {a,b,c,d,e,f,g}. Glyph values in decimal:
  0=126, 1=48, 2=109, 3=121, 4=51, 5=91, 6=95, 7=112, 8=127, 9=123, A=119, b=31, C=78, d=61, E=79, F=71.
- J1 = glyph(V/10) with range 0..6 and no leading-zero blanking (V<10 shows 0). J2 = glyph(V%10).
- J3 = glyph(V[5:4]). J4 = glyph(V[3:0]) using the hex glyphs A..F.
- J5 = glyph(number of set bits in V).
- J6 = glyph(k), where k is the smallest index with SWk=1, so SW1 has highest priority. J6 = glyph(0) when V=0.
- Dk = SWk as sampled at the edge.
- Unused glyph codes are unreachable. The decoder default returns 7'd0.
- No other state, counters or handshakes exist.

Test Plan:
- Reset: hold rst_n=0 with V=63, toggle clk -> all J=0, all D=0. Release, one edge -> the V=63 values below.
- V=0, one edge -> J1..J6 = 126,126,126,126,126,126; D1..D6 = 0.
- V=63, one edge -> J1=95, J2=121, J3=121, J4=71, J5=95, J6=48; D1..D6 = 1.
- V=37 (SW1,SW4,SW6 on), one edge -> J1=121, J2=112, J3=109, J4=91, J5=121, J6=48; D = 1,0,0,1,0,1.
- V=10 (SW3,SW5 on), one edge -> J1=48, J2=126, J3=126, J4=119, J5=109, J6=121; D = 0,0,1,0,1,0.
- Exhaustive sweep V=0..63, one edge each -> every output matches the reference model. Change V mid-cycle -> outputs unchanged until the next edge. Assert rst_n mid-sweep -> outputs clear immediately.
